// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, single-cycle ALU/branch, iterative MUL/DIVU/REMU.
// Ports: clk, rst (async active-low), flush, in/out valid-ready handshake, operands, result/newPC/takeBr, busy.
module execute_mc #(
    parameter int WIDTH   = 16,
    parameter int NUM_FWD = 4,
    parameter int SELW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [3:0]               opcode,
    input  logic [2:0]               brchSig,
    input  logic [WIDTH-1:0]         inA,
    input  logic [WIDTH-1:0]         inB,
    input  logic [SELW-1:0]          fwSelA,
    input  logic [SELW-1:0]          fwSelB,
    input  logic [NUM_FWD*WIDTH-1:0] fwData,
    input  logic [WIDTH-1:0]         incPC,
    input  logic [WIDTH-1:0]         imm,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         newPC,
    output logic                     takeBr,
    output logic                     busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       md_q, md_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] newpc_q, newpc_d;
    logic             takebr_q, takebr_d;
    logic             outvalid_q, outvalid_d;

    logic [WIDTH-1:0] fa, fb, alu_res;
    logic [WIDTH-1:0] acc_step, q_step, b_step;
    logic [WIDTH:0]   r_sh, diff;
    logic             accept, out_free, is_md, br_taken;

    // md_q: 0 = MUL (acc holds product), 1 = DIVU (q holds quotient), 2 = REMU (acc holds remainder)
    function automatic logic [WIDTH-1:0] md_pick(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] q);
        return (op == 2'd1) ? q : acc;
    endfunction

    always_comb begin
        fa = inA;
        fb = inB;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwSelA == SELW'(k)) fa = fwData[(k-1)*WIDTH +: WIDTH];
            if (fwSelB == SELW'(k)) fb = fwData[(k-1)*WIDTH +: WIDTH];
        end
    end

    assign out_free = ~outvalid_q | outReady;
    assign inReady  = (state_q == IDLE) & out_free & ~flush;
    assign accept   = inValid & inReady;
    assign is_md    = (opcode == 4'd8) | (opcode == 4'd9) | (opcode == 4'd10);

    always_comb begin
        case (opcode)
            4'd0:    alu_res = fa + fb;
            4'd1:    alu_res = fa - fb;
            4'd2:    alu_res = fa & fb;
            4'd3:    alu_res = fa | fb;
            4'd4:    alu_res = fa ^ fb;
            4'd5:    alu_res = ($signed(fa) < $signed(fb)) ? WIDTH'(1) : '0;
            4'd6:    alu_res = fa << fb[SHW-1:0];
            4'd7:    alu_res = fa >> fb[SHW-1:0];
            4'd12:   alu_res = imm;
            default: alu_res = '0;
        endcase
        case (brchSig)
            3'b000:  br_taken = (fa == '0);
            3'b001:  br_taken = (fa != '0);
            3'b010:  br_taken = fa[WIDTH-1];
            3'b011:  br_taken = ~fa[WIDTH-1];
            default: br_taken = 1'b0;
        endcase
    end

    // One iteration: MUL is LSB-first shift-add (q = multiplier, b = shifted multiplicand);
    // DIV is restoring (q shifts dividend out / quotient in, acc = partial remainder).
    // A zero divisor never subtracts-negative, giving all-ones quotient and remainder = A.
    always_comb begin
        r_sh = {acc_q, q_q[WIDTH-1]};
        diff = r_sh - {1'b0, b_q};
        if (md_q == 2'd0) begin
            acc_step = acc_q + (q_q[0] ? b_q : '0);
            q_step   = q_q >> 1;
            b_step   = b_q << 1;
        end else begin
            acc_step = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            q_step   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
            b_step   = b_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_d       = md_q;
        acc_d      = acc_q;
        q_d        = q_q;
        b_d        = b_q;
        pc_d       = pc_q;
        result_d   = result_q;
        newpc_d    = newpc_q;
        takebr_d   = takebr_q;
        outvalid_d = outvalid_q;
        if (outvalid_q & outReady) outvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_md) begin
                        state_d = ITER;
                        cnt_d   = CW'(WIDTH - 1);
                        md_d    = opcode[1:0];
                        acc_d   = '0;
                        q_d     = fa;
                        b_d     = fb;
                        pc_d    = incPC;
                    end else begin
                        result_d   = alu_res;
                        takebr_d   = (opcode == 4'd11) & br_taken;
                        newpc_d    = takebr_d ? incPC + imm : incPC;
                        outvalid_d = 1'b1;
                    end
                end
            end
            ITER: begin
                acc_d = acc_step;
                q_d   = q_step;
                b_d   = b_step;
                cnt_d = cnt_q - 1'b1;
                // Final step writes straight to the output when it is free,
                // so DONE is only visited when the output is blocked.
                if (cnt_q == '0) begin
                    if (out_free) begin
                        result_d   = md_pick(md_q, acc_step, q_step);
                        newpc_d    = pc_q;
                        takebr_d   = 1'b0;
                        outvalid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_free) begin
                    result_d   = md_pick(md_q, acc_q, q_q);
                    newpc_d    = pc_q;
                    takebr_d   = 1'b0;
                    outvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            outvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            md_q       <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            result_q   <= '0;
            newpc_q    <= '0;
            takebr_q   <= 1'b0;
            outvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_q       <= md_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            b_q        <= b_d;
            pc_q       <= pc_d;
            result_q   <= result_d;
            newpc_q    <= newpc_d;
            takebr_q   <= takebr_d;
            outvalid_q <= outvalid_d;
        end
    end

    assign outValid = outvalid_q;
    assign result   = result_q;
    assign newPC    = newpc_q;
    assign takeBr   = takebr_q;
    assign busy     = (state_q == ITER);
endmodule

// File: tb/tb_execute_mc.sv
// Directed self-checking bench for execute_mc (WIDTH=16, NUM_FWD=4, SELW=3).
// Checks reset, ALU ops, forwarding, branches, MUL/DIV latency, output hold, flush and async reset.
module tb_execute_mc;
    localparam int W  = 16;
    localparam int NF = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst, flush, inValid, inReady, outValid, outReady, takeBr, busy;
    logic [3:0]    opcode;
    logic [2:0]    brchSig;
    logic [W-1:0]  inA, inB, incPC, imm, result, newPC;
    logic [SW-1:0] fwSelA, fwSelB;
    logic [NF*W-1:0] fwData;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_mc #(.WIDTH(W), .NUM_FWD(NF), .SELW(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .opcode(opcode), .brchSig(brchSig),
        .inA(inA), .inB(inB),
        .fwSelA(fwSelA), .fwSelB(fwSelB), .fwData(fwData),
        .incPC(incPC), .imm(imm),
        .outValid(outValid), .outReady(outReady),
        .result(result), .newPC(newPC), .takeBr(takeBr), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] im);
        opcode = op;
        inA    = a;
        inB    = b;
        imm    = im;
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] im, input logic [W-1:0] exp);
        drive(op, a, b, im);
        inValid = 1'b1;
        step();
        chk(tag, {outValid, result}, {1'b1, exp});
    endtask

    task automatic run_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int lat, busy_n, bad;
        drive(op, a, b, 16'h0);
        inValid = 1'b1;
        #1;
        chk({tag, "_rdy"}, inReady, 1);
        step();
        inValid = 1'b0;
        lat     = 1;
        busy_n  = 0;
        bad     = 0;
        while (!outValid && lat < 40) begin
            if (busy) busy_n++;
            if (inReady) bad++;
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_busy"}, busy_n, 16);
        chk({tag, "_stall"}, bad, 0);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_pc"}, {takeBr, newPC}, {1'b0, incPC});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        opcode = '0; brchSig = '0; inA = '0; inB = '0; imm = '0; incPC = '0;
        fwSelA = '0; fwSelB = '0; fwData = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_flags", {outValid, busy, takeBr}, 0);
        chk("rst_res", result, 0);
        chk("rst_pc", newPC, 0);
        step();
        step();
        rst = 1'b1;

        // Forwarded ADD: slice 1 = 0x0010, slice 3 = 0x0100
        fwData = {16'h0100, 16'h0000, 16'h0010, 16'h0000};
        fwSelA = 3'd2;
        drive(4'd0, 16'h0000, 16'h0005, 16'h0);
        incPC   = 16'h0010;
        inValid = 1'b1;
        #1;
        chk("add_rdy", inReady, 1);
        step();
        chk("add_fwd", {outValid, result}, {1'b1, 16'h0015});
        chk("add_pc", {takeBr, newPC}, {1'b0, 16'h0010});
        fwSelA = '0;

        // Output blocked for 3 cycles with a SUB waiting
        drive(4'd1, 16'h0009, 16'h0003, 16'h0);
        repeat (3) begin
            #1;
            chk("hold_rdy", inReady, 0);
            chk("hold_res", {outValid, result}, {1'b1, 16'h0015});
            step();
        end
        outReady = 1'b1;
        #1;
        chk("drain_rdy", inReady, 1);
        step();
        chk("b2b_sub", {outValid, result}, {1'b1, 16'h0006});

        alu("and",   4'd2,  16'hF0F0, 16'h0FF0, 16'h0, 16'h00F0);
        alu("or",    4'd3,  16'hF0F0, 16'h0FF0, 16'h0, 16'hFFF0);
        alu("xor",   4'd4,  16'hF0F0, 16'h0FF0, 16'h0, 16'hFF00);
        alu("slt_t", 4'd5,  16'h8000, 16'h0001, 16'h0, 16'h0001);
        alu("slt_f", 4'd5,  16'h0001, 16'h8000, 16'h0, 16'h0000);
        alu("sll",   4'd6,  16'h0001, 16'h0013, 16'h0, 16'h0008);
        alu("srl",   4'd7,  16'h8000, 16'h0004, 16'h0, 16'h0800);
        alu("sub_w", 4'd1,  16'h0000, 16'h0001, 16'h0, 16'hFFFF);
        alu("add_w", 4'd0,  16'hFFFF, 16'h0002, 16'h0, 16'h0001);
        alu("passb", 4'd12, 16'h5555, 16'h5555, 16'h1234, 16'h1234);
        alu("op14",  4'd14, 16'h5555, 16'h5555, 16'h1234, 16'h0000);
        fwSelA = 3'd7;
        fwSelB = 3'd4;
        alu("fwd_sel", 4'd0, 16'h0001, 16'h2222, 16'h0, 16'h0101);
        fwSelA = '0;
        fwSelB = '0;

        // Branches
        brchSig = 3'b010;
        incPC   = 16'hFFFE;
        alu("br_lt", 4'd11, 16'h8000, 16'h0, 16'h0004, 16'h0000);
        chk("br_lt_pc", {takeBr, newPC}, {1'b1, 16'h0002});
        brchSig = 3'b000;
        incPC   = 16'h0040;
        alu("br_eq", 4'd11, 16'h0001, 16'h0, 16'h0010, 16'h0000);
        chk("br_eq_pc", {takeBr, newPC}, {1'b0, 16'h0040});
        brchSig = 3'b001;
        alu("br_ne", 4'd11, 16'h0001, 16'h0, 16'h0010, 16'h0000);
        chk("br_ne_pc", {takeBr, newPC}, {1'b1, 16'h0050});
        brchSig = 3'b011;
        alu("br_ge", 4'd11, 16'h8000, 16'h0, 16'h0010, 16'h0000);
        chk("br_ge_pc", {takeBr, newPC}, {1'b0, 16'h0040});
        brchSig = 3'b111;
        alu("br_nv", 4'd11, 16'h0000, 16'h0, 16'h0010, 16'h0000);
        chk("br_nv_pc", {takeBr, newPC}, {1'b0, 16'h0040});
        inValid = 1'b0;

        // Multi-cycle unit
        incPC = 16'h0100;
        run_md("mul",   4'd8,  16'h0123, 16'h0004, 16'h048C);
        run_md("divz",  4'd9,  16'h0064, 16'h0000, 16'hFFFF);
        run_md("remz",  4'd10, 16'h0064, 16'h0000, 16'h0064);
        run_md("div7",  4'd9,  16'h0064, 16'h0007, 16'h000E);
        run_md("rem7",  4'd10, 16'h0064, 16'h0007, 16'h0002);
        run_md("mulw",  4'd8,  16'hFFFF, 16'hFFFF, 16'h0001);

        // Flush at ITER cycle 5 of a DIVU
        drive(4'd9, 16'h0064, 16'h0007, 16'h0);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        repeat (4) step();
        chk("fl_pre_busy", busy, 1);
        flush = 1'b1;
        #1;
        chk("fl_rdy", inReady, 0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_post", {busy, outValid, inReady}, 3'b001);

        // Async reset in the middle of a MUL
        incPC = 16'h0200;
        alu("pre_rst", 4'd0, 16'h0001, 16'h0002, 16'h0, 16'h0003);
        drive(4'd8, 16'h0003, 16'h0005, 16'h0);
        step();
        inValid = 1'b0;
        step();
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_flags", {outValid, busy, takeBr}, 0);
        chk("arst_res", result, 0);
        chk("arst_pc", newPC, 0);
        chk("arst_rdy", inReady, 1);
        step();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
